gpio_ctrl_apb_master: RTL and testbench
=======================================

GPIO_CTRL_APB_MASTER -- requirements
Module: gpio_ctrl_apb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles before abort; legal range 1..65535.
REQ-003 Port clk, in, 1, single clock; all logic on the rising edge.
REQ-004 Port rst, in, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 Port cmd_valid/cmd_ready, in/out, 1/1, command handshake.
REQ-006 Port cmd_write, cmd_addr, cmd_strb, cmd_wdata, in, 1/ADDR_WIDTH/4/32, command fields.
REQ-007 Port rsp_valid/rsp_ready, out/in, 1/1, response handshake.
REQ-008 Port rsp_rdata, rsp_err, rsp_timeout, out, 32/1/1, response fields.
REQ-009 Port paddr, pwrite, psel, penable, pstrb, pwdata, out, ADDR_WIDTH/1/1/1/4/32, APB initiator outputs.
REQ-010 Port prdata, pready, pslverr, in, 32/1/1, APB responder inputs.

Function
REQ-011 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, with one transfer outstanding at most.
REQ-012 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-013 On acceptance, the block SHALL register all cmd fields and enter SETUP on the next edge.
REQ-014 SETUP SHALL drive psel=1, penable=0 for exactly one cycle, then enter ACCESS.
REQ-015 ACCESS SHALL drive psel=1, penable=1 until a cycle with pready=1, then enter RESP.
REQ-016 paddr, pwrite, pstrb and pwdata SHALL be held stable from SETUP through the last ACCESS cycle.
REQ-017 pstrb SHALL be 4'b0000 on reads regardless of cmd_strb.
REQ-018 In IDLE and RESP, psel, penable, paddr, pwrite, pstrb and pwdata SHALL all be 0.
REQ-019 On the completing ACCESS cycle, rsp_rdata SHALL capture prdata for reads and 0 for writes, and rsp_err SHALL capture pslverr.
REQ-020 RESP SHALL hold rsp_valid=1 with stable fields until rsp_ready=1, then return to IDLE.
REQ-021 Latency SHALL be: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3 when pready is already 1.
REQ-022 Back-to-back commands SHALL incur no extra bubble: cmd_ready rises on the cycle after response acceptance.
REQ-023 prdata and pslverr SHALL be ignored when pready=0.

Reset
REQ-024 On rst=1 the FSM SHALL enter IDLE, and every output SHALL be 0 except cmd_ready, which SHALL be 1 from the first cycle after reset.
REQ-025 Reset during SETUP or ACCESS SHALL abort the transfer without a response, with psel and penable at 0 after the reset edge.

Configuration
REQ-026 With GPIO_CTRL_APB_TIMEOUT_EN defined, a 16-bit counter SHALL count ACCESS cycles with pready=0 and clear on entry to SETUP.
REQ-027 With the macro defined, when the count reaches TIMEOUT_CYCLES the block SHALL deassert psel/penable on the next edge, enter RESP, and set rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-028 With the macro defined, pready=1 on the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally, with no timeout.
REQ-029 Without the macro, ACCESS SHALL wait indefinitely, no counter SHALL exist, and rsp_timeout SHALL be tied to 0.

Structure
REQ-030 Package gpio_ctrl_pkg SHALL hold the state enum (apb_mst_state_e) and the default TIMEOUT_CYCLES constant.
REQ-031 The timeout counter SHALL be sub-module gpio_ctrl_apb_timer, instantiated only under GPIO_CTRL_APB_TIMEOUT_EN; all other logic stays in gpio_ctrl_apb_master.

Verification
REQ-032 Write addr=0x004, wdata=0xDEADBEEF, strb=0xF with pready tied 1 -> SETUP then ACCESS with psel/penable 10 then 11, rsp_valid 3 cycles after accept, rsp_err=0.
REQ-033 Read addr=0x3FC, strb=0xF, prdata=0x12345678 with pready low for 3 ACCESS cycles -> pstrb=0, 5 ACCESS-stretched cycles total, rsp_rdata=0x12345678.
REQ-034 Write with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0; with rsp_ready held 0 for 4 cycles, the response fields are stable and cmd_ready stays 0.
REQ-035 With GPIO_CTRL_APB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and pready stuck 0 -> psel drops after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-036 rst=1 asserted in the second ACCESS cycle -> psel=penable=0 and no rsp_valid after the reset edge, then cmd_ready=1 and a following read completes correctly.
REQ-037 Four back-to-back reads with rsp_ready tied 1 -> each transfer takes 4 cycles, and cmd_ready=1 exactly once per transfer.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared types for the GPIO controller APB initiator: FSM state encoding and
// the default ACCESS timeout used when GPIO_CTRL_APB_TIMEOUT_EN is defined.
package gpio_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/gpio_ctrl_apb_timer.sv
// ACCESS wait-state counter; only instantiated when GPIO_CTRL_APB_TIMEOUT_EN is defined.
// expired flags the stalled cycle on which the count reaches LIMIT.
module gpio_ctrl_apb_timer #(
  parameter logic [15:0] LIMIT = 16'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)    cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 16'd1;
  end

  assign expired = inc && (cnt_q == LIMIT - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gpio_ctrl_apb_master.sv
// Single-outstanding APB initiator bridging a valid/ready command/response pair.
// Optional ACCESS timeout is enabled by defining GPIO_CTRL_APB_TIMEOUT_EN.
module gpio_ctrl_apb_master
  import gpio_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_strb,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [3:0]            pstrb,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  apb_mst_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [3:0]            strb_q, strb_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  active;

`ifdef GPIO_CTRL_APB_TIMEOUT_EN
  logic tmo_q, tmo_d;
  logic tmo_hit;

  // Counter restarts on every accepted command, i.e. on entry to SETUP.
  gpio_ctrl_apb_timer #(
    .LIMIT (16'(TIMEOUT_CYCLES))
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (cmd_valid && cmd_ready),
    .inc     ((state_q == ST_ACCESS) && !pready),
    .expired (tmo_hit)
  );

  assign rsp_timeout = tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          write_d = cmd_write;
          strb_d  = cmd_strb;
          wdata_d = cmd_wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A completing pready wins over a timeout landing on the same cycle.
        if (pready) begin
          rdata_d = write_q ? 32'd0 : prdata;
          err_d   = pslverr;
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
        else if (tmo_hit) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Bus fields are forced to zero outside the SETUP/ACCESS window.
  assign active    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = active;
  assign penable   = (state_q == ST_ACCESS);
  assign paddr     = active ? addr_q : '0;
  assign pwrite    = active && write_q;
  assign pstrb     = (active && write_q) ? strb_q : 4'd0;
  assign pwdata    = active ? wdata_q : 32'd0;

endmodule

// File: tb/tb_gpio_ctrl_apb_master.sv
// Self-checking bench for gpio_ctrl_apb_master: vector table plus scoreboard,
// with hand-written sequences for response hold, reset abort and back-to-back traffic.
module tb_gpio_ctrl_apb_master;

  localparam int AW  = 10;
  localparam int TMO = 8;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [3:0]    strb;
    logic [31:0]   wdata;
    logic [31:0]   prdata;
    logic          slverr;
    int            waitc;
    logic [31:0]   exp_rdata;
    logic          exp_err;
    logic          exp_tmo;
    logic [3:0]    exp_pstrb;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc_cyc;
  } txn_t;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [3:0]    cmd_strb;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] paddr;
  logic          pwrite, psel, penable;
  logic [3:0]    pstrb;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_seen = 0;
  int   cr_cnt = 0;
  int   last_acc = 0;
  bit   abort = 0;
  txn_t expq[$];
  vec_t cfgq[$];

  gpio_ctrl_apb_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_strb(cmd_strb), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int exp_acc(input vec_t v);
    return v.exp_tmo ? TMO : v.waitc + 1;
  endfunction

  // APB responder and bus monitor: decides pready for the current cycle on the
  // falling edge, and drives junk read data / slverr while stalled.
  vec_t cur;
  int   acc_n = 0;
  int   psel_n = 0;
  bit   prev_rv = 0;
  always @(negedge clk) begin
    if (cmd_ready) cr_cnt++;
    if (psel && !penable) begin
      pready = 1'b0; prdata = 32'hBAD0BAD0; pslverr = 1'b1;
      acc_n = 0; psel_n = 1;
      if (cfgq.size() == 0) chk("setup_without_cmd", 32'd1, 32'd0);
      else begin
        cur = cfgq.pop_front();
        chk("setup_paddr", 32'(paddr), 32'(cur.addr));
        chk("setup_pwrite", 32'(pwrite), 32'(cur.write));
        chk("setup_pstrb", 32'(pstrb), 32'(cur.exp_pstrb));
        chk("setup_pwdata", pwdata, cur.wdata);
      end
    end else if (psel && penable) begin
      psel_n++;
      if (!rst)
        chk("access_hold", {paddr, pwrite, pstrb} ^ 32'(pwdata),
            {cur.addr, cur.write, cur.exp_pstrb} ^ 32'(cur.wdata));
      pready = (acc_n >= cur.waitc);
      acc_n++;
      if (pready) begin prdata = cur.prdata; pslverr = cur.slverr; end
      else begin prdata = 32'hBAD0BAD0; pslverr = 1'b1; end
    end else begin
      pready = 1'b0; prdata = $urandom; pslverr = 1'b0;
      if (!rst && (penable || pwrite || paddr != '0 || pstrb != 4'd0 || pwdata != 32'd0))
        chk("idle_bus_zero", {penable, pwrite, pstrb, paddr} ^ pwdata, 32'd0);
      if (psel_n > 0) begin
        if (!abort) chk("psel_cycles", 32'(psel_n), 32'(1 + exp_acc(cur)));
        abort = 0;
        psel_n = 0;
      end
    end
    if (!rst) begin
      if (rsp_valid && !prev_rv && expq.size() > 0)
        chk("latency", 32'(cyc - expq[0].acc_cyc), 32'(2 + exp_acc(expq[0].v)));
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (expq.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          txn_t t;
          t = expq.pop_front();
          chk("rsp_rdata", rsp_rdata, t.v.exp_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(t.v.exp_err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(t.v.exp_tmo));
        end
      end
    end
    prev_rv = rsp_valid;
  end

  // Starts and ends just after a rising edge; pushes the scoreboard on accept.
  task automatic send(input vec_t v);
    int n;
    txn_t t;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_strb = v.strb; cmd_wdata = v.wdata;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++n > 200) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    t.v = v; t.acc_cyc = cyc;
    last_acc = cyc;
    expq.push_back(t);
    cfgq.push_back(v);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (expq.size() > 0) begin
      chk("drain_timeout", 32'(expq.size()), 32'd0);
      expq.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  vec_t v;
  int   acc_cycs[4];
  int   cr0, seen0, n;

  initial begin
    // write, addr, strb, wdata, prdata, slverr, wait, exp_rdata, exp_err, exp_tmo, exp_pstrb
    vecs.push_back('{1'b1, 10'h004, 4'hF, 32'hDEADBEEF, 32'h11111111, 1'b0, 0, 32'h0,        1'b0, 1'b0, 4'hF});
    vecs.push_back('{1'b0, 10'h3FC, 4'hF, 32'h0BADCAFE, 32'h12345678, 1'b0, 3, 32'h12345678, 1'b0, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 10'h155, 4'h5, 32'hA5A50F0F, 32'h22222222, 1'b0, 1, 32'h0,        1'b0, 1'b0, 4'h5});
    vecs.push_back('{1'b0, 10'h000, 4'hA, 32'h33333333, 32'hCAFEF00D, 1'b1, 2, 32'hCAFEF00D, 1'b1, 1'b0, 4'h0});
    vecs.push_back('{1'b1, 10'h2AA, 4'h0, 32'h44444444, 32'h55555555, 1'b1, 0, 32'h0,        1'b1, 1'b0, 4'h0});
    vecs.push_back('{1'b0, 10'h3FF, 4'h3, 32'h0,        32'hFFFFFFFF, 1'b0, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0});
`ifdef GPIO_CTRL_APB_TIMEOUT_EN
    vecs.push_back('{1'b0, 10'h0F0, 4'hF, 32'h0,        32'h99999999, 1'b0, 1000, 32'h0,     1'b1, 1'b1, 4'h0});
    vecs.push_back('{1'b0, 10'h0F4, 4'hF, 32'h0,        32'h87654321, 1'b0, TMO - 1, 32'h87654321, 1'b0, 1'b0, 4'h0});
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_strb = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_apb_ctl", {psel, penable, pwrite, rsp_valid}, 32'd0);
    chk("reset_apb_data", {pstrb, paddr} ^ pwdata, 32'd0);
    chk("reset_rsp", rsp_rdata ^ {rsp_err, rsp_timeout}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Vector table
    rsp_ready = 1'b1;
    foreach (vecs[i]) send(vecs[i]);
    drain();
    idle(2);

    // Error response held with rsp_ready low
    v = '{1'b1, 10'h010, 4'hF, 32'h00000001, 32'h0, 1'b1, 0, 32'h0, 1'b1, 1'b0, 4'hF};
    rsp_ready = 1'b0;
    send(v);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_fields", {rsp_err, rsp_timeout}, 32'd2);
      chk("hold_rsp_rdata", rsp_rdata, 32'd0);
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();
    idle(2);

    // Reset in the second ACCESS cycle aborts without a response
    v = '{1'b0, 10'h0AA, 4'hF, 32'h0, 32'h77777777, 1'b0, 5, 32'h77777777, 1'b0, 1'b0, 4'h0};
    send(v);
    idle(1);
    idle(1);
    rst = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_in_access", {psel, penable}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    seen0 = rsp_seen;
    @(negedge clk);
    chk("abort_apb_idle", {psel, penable, rsp_valid}, 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    idle(5);
    chk("abort_no_rsp", 32'(rsp_seen - seen0), 32'd0);
    v = '{1'b0, 10'h1C4, 4'hF, 32'h0, 32'h5A5A1234, 1'b0, 1, 32'h5A5A1234, 1'b0, 1'b0, 4'h0};
    send(v);
    drain();
    idle(2);

    // Four back-to-back reads
    cr0 = cr_cnt;
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, AW'(10'h100 + 4 * i), 4'hF, 32'h0, 32'hB0B00000 + 32'(i), 1'b0, 0,
            32'hB0B00000 + 32'(i), 1'b0, 1'b0, 4'h0};
      send(v);
      acc_cycs[i] = last_acc;
    end
    chk("b2b_cmd_ready_cnt", 32'(cr_cnt - cr0), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("b2b_period", 32'(acc_cycs[i] - acc_cycs[i-1]), 32'd4);
    drain();
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
